// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone B3 arbiter: merges the code and data zap_cache _nxt buses onto one registered bus.
// Grant moves only at idle, EOB ack or watchdog timeout; ACK/ERR return combinationally to the owner.
module zap_wb_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        i_clk,
   input  logic        i_reset,

   input  logic        i_c_wb_cyc_nxt,
   input  logic        i_c_wb_stb_nxt,
   input  logic        i_c_wb_wen_nxt,
   input  logic [3:0]  i_c_wb_sel_nxt,
   input  logic [31:0] i_c_wb_dat_nxt,
   input  logic [31:0] i_c_wb_adr_nxt,
   input  logic [2:0]  i_c_wb_cti_nxt,
   output logic        o_c_wb_ack,
   output logic        o_c_wb_err,

   input  logic        i_d_wb_cyc_nxt,
   input  logic        i_d_wb_stb_nxt,
   input  logic        i_d_wb_wen_nxt,
   input  logic [3:0]  i_d_wb_sel_nxt,
   input  logic [31:0] i_d_wb_dat_nxt,
   input  logic [31:0] i_d_wb_adr_nxt,
   input  logic [2:0]  i_d_wb_cti_nxt,
   output logic        o_d_wb_ack,
   output logic        o_d_wb_err,

   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_wen,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_dat,
   output logic [31:0] o_wb_adr,
   output logic [2:0]  o_wb_cti,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_ack,
   input  logic        i_wb_err
);

   localparam logic       CODE    = 1'b0;
   localparam logic       DATA    = 1'b1;
   localparam logic [2:0] CTI_EOB = 3'b111;
   localparam int         CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0);
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic          owner_q, owner_d;
   logic          last_winner_q, last_winner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cyc_q, cyc_d, stb_q, stb_d, wen_q, wen_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   dat_q, dat_d, adr_q, adr_d;
   logic [2:0]    cti_q, cti_d;
   logic          timeout;
   logic          boundary;
   logic          unused_rd_dat;

   // Read data goes straight from the bus to both caches, bypassing the arbiter.
   assign unused_rd_dat = ^i_wb_dat;

   assign timeout  = (TIMEOUT_CYCLES > 0) && stb_q && !i_wb_ack && (cnt_q == CNT_LAST);
   assign boundary = !cyc_q || (stb_q && i_wb_ack && (cti_q == CTI_EOB)) || timeout;

   always_comb begin
      cnt_d = cnt_q;
      if ((TIMEOUT_CYCLES == 0) || !stb_q || i_wb_ack || timeout) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Any grant, contested or not, becomes the new last_winner so round-robin stays fair.
   always_comb begin
      owner_d       = owner_q;
      last_winner_d = last_winner_q;
      if (boundary) begin
         case ({i_c_wb_cyc_nxt, i_d_wb_cyc_nxt})
            2'b10:   owner_d = CODE;
            2'b01:   owner_d = DATA;
            2'b11:   owner_d = ~last_winner_q;
            default: owner_d = owner_q;
         endcase
         if (i_c_wb_cyc_nxt || i_d_wb_cyc_nxt) begin
            last_winner_d = owner_d;
         end
      end
   end

   always_comb begin
      if (owner_d == CODE) begin
         cyc_d = i_c_wb_cyc_nxt;
         stb_d = i_c_wb_stb_nxt;
         wen_d = i_c_wb_wen_nxt;
         sel_d = i_c_wb_sel_nxt;
         dat_d = i_c_wb_dat_nxt;
         adr_d = i_c_wb_adr_nxt;
         cti_d = i_c_wb_cti_nxt;
      end else begin
         cyc_d = i_d_wb_cyc_nxt;
         stb_d = i_d_wb_stb_nxt;
         wen_d = i_d_wb_wen_nxt;
         sel_d = i_d_wb_sel_nxt;
         dat_d = i_d_wb_dat_nxt;
         adr_d = i_d_wb_adr_nxt;
         cti_d = i_d_wb_cti_nxt;
      end
      if (timeout) begin
         cyc_d = 1'b0;
         stb_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         owner_q       <= CODE;
         last_winner_q <= DATA;
         cnt_q         <= '0;
         cyc_q         <= 1'b0;
         stb_q         <= 1'b0;
         wen_q         <= 1'b0;
         sel_q         <= '0;
         dat_q         <= '0;
         adr_q         <= '0;
         cti_q         <= CTI_EOB;
      end else begin
         owner_q       <= owner_d;
         last_winner_q <= last_winner_d;
         cnt_q         <= cnt_d;
         cyc_q         <= cyc_d;
         stb_q         <= stb_d;
         wen_q         <= wen_d;
         sel_q         <= sel_d;
         dat_q         <= dat_d;
         adr_q         <= adr_d;
         cti_q         <= cti_d;
      end
   end

   assign o_wb_cyc = cyc_q;
   assign o_wb_stb = stb_q;
   assign o_wb_wen = wen_q;
   assign o_wb_sel = sel_q;
   assign o_wb_dat = dat_q;
   assign o_wb_adr = adr_q;
   assign o_wb_cti = cti_q;

   assign o_c_wb_ack = (owner_q == CODE) && (i_wb_ack || timeout);
   assign o_c_wb_err = (owner_q == CODE) && (i_wb_err || timeout);
   assign o_d_wb_ack = (owner_q == DATA) && (i_wb_ack || timeout);
   assign o_d_wb_err = (owner_q == DATA) && (i_wb_err || timeout);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         assert (i_wb_ack || !i_wb_err) else $fatal(1, "zap_wb_arbiter: i_wb_err asserted without i_wb_ack");
      end
   end

endmodule
